// File: rtl/cpu_pkg.sv
// cpu_pkg: core-wide widths, reset vector and opcode constants shared by fetch and decode.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic int wrap_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of instruction word plus its pc, with single-cycle flush.
module fetch_queue import cpu_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [ILEN-1:0] push_data,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  output logic            valid,
  output logic [ILEN-1:0] head_data,
  output logic [XLEN-1:0] head_pc,
  output logic [CW-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [ILEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  // a pop frees the slot the same-cycle push may land in, so full+push+pop is legal
  assign do_pop  = pop && cnt_q != '0 && !flush;
  assign do_push = push && (cnt_q != CW'(DEPTH) || do_pop) && !flush;

  always_comb begin
    rd_d  = flush ? '0 : do_pop ? AW'(wrap_inc(int'(rd_q), DEPTH)) : rd_q;
    wr_d  = flush ? '0 : do_push ? AW'(wrap_inc(int'(wr_q), DEPTH)) : wr_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wr_q] <= push_data;
      pc_q[wr_q]   <= push_pc;
    end
  end

  assign valid     = cnt_q != '0;
  assign head_data = data_q[rd_q];
  assign head_pc   = pc_q[rd_q];
  assign count     = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with pc-tag FIFO, instruction queue and
// redirect flush that discards responses still in flight.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = CW + 1;
  localparam int AW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, qcnt;
  logic [XLEN-1:0] tag_q [QDEPTH];
  logic [AW-1:0] trd_q, trd_d, twr_q, twr_d;
  logic acc, rsp, keep;

  // out_q counts every request in flight, discarded ones included, so credit stays exact
  assign imem_req_valid = rst_n && !redirect_valid && (SW'(out_q) + SW'(qcnt) < SW'(QDEPTH));
  assign imem_addr      = pc_q;
  assign acc            = imem_req_valid && imem_req_ready;
  assign rsp            = imem_rsp_valid && out_q != '0;
  assign keep           = rsp && disc_q == '0 && !redirect_valid;

  always_comb begin
    pc_d   = redirect_valid ? (redirect_pc & ~XLEN'(3)) : acc ? pc_q + XLEN'(4) : pc_q;
    out_d  = out_q + CW'(acc) - CW'(rsp);
    disc_d = redirect_valid ? out_d : disc_q - CW'(rsp && disc_q != '0);
    trd_d  = redirect_valid ? '0 : keep ? AW'(wrap_inc(int'(trd_q), QDEPTH)) : trd_q;
    twr_d  = redirect_valid ? '0 : acc ? AW'(wrap_inc(int'(twr_q), QDEPTH)) : twr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC & ~XLEN'(3);
      out_q  <= '0;
      disc_q <= '0;
      trd_q  <= '0;
      twr_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      trd_q  <= trd_d;
      twr_q  <= twr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) tag_q[twr_q] <= pc_q;
  end

  fetch_queue #(.DEPTH(QDEPTH), .CW(CW)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (keep),
    .push_data (imem_rsp_data),
    .push_pc   (tag_q[trd_q]),
    .pop       (instr_ready),
    .valid     (instr_valid),
    .head_data (instr),
    .head_pc   (instr_pc),
    .count     (qcnt)
  );

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
endmodule
